// File: rtl/inv_mix_columns_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inv_mix_columns_seq_pkg
//  Description : Shared AES widths, control-state encoding and GF(2^8)
//                helpers for the iterative InvMixColumns engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package inv_mix_columns_seq_pkg;

    localparam int STATE_W   = 128;
    localparam int COL_W     = 32;
    localparam int NCOLS     = 4;
    localparam int BYTE_W    = 8;
    localparam int NROWS     = COL_W / BYTE_W;
    localparam int COL_IDX_W = 2;

    // Control states; 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // MSB position of column idx; column 0 occupies the top 32 bits.
    function automatic int col_msb(input int idx);
        return STATE_W - 1 - COL_W * idx;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? 8'h1b : 8'h00);
    endfunction

    // Multiply a byte by a 4-bit constant (9, 11, 13, 14 for the inverse mix)
    // by summing the doubled terms selected by the constant's bits.
    function automatic logic [BYTE_W-1:0] gf_mul_const(input logic [BYTE_W-1:0] b,
                                                       input logic [3:0]        k);
        logic [BYTE_W-1:0] x2;
        logic [BYTE_W-1:0] x4;
        logic [BYTE_W-1:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? b  : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^
               (k[3] ? x8 : 8'h00);
    endfunction

endpackage : inv_mix_columns_seq_pkg
`default_nettype wire

// File: rtl/inv_mix_columns_seq_single_column.sv
`default_nettype none
// ============================================================================
//  Module      : inv_mix_columns_seq_single_column
//  Description : Combinational Inverse_Mix_SingleColumn: one 32-bit column
//                multiplied by the circulant {0e,0b,0d,09} matrix.
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_mix_columns_seq_single_column
    import inv_mix_columns_seq_pkg::*;
(
    input  logic [COL_W-1:0] current_column,
    output logic [COL_W-1:0] new_column
);

    // Byte r of the column; byte 0 sits in the MSBs.
    logic [BYTE_W-1:0] w_byte [NROWS];

    for (genvar r = 0; r < NROWS; r++) begin : g_byte
        assign w_byte[r] = current_column[COL_W-1-BYTE_W*r -: BYTE_W];
    end

    // Each output row rotates the coefficient vector {e,b,d,9} one byte right.
    for (genvar r = 0; r < NROWS; r++) begin : g_row
        assign new_column[COL_W-1-BYTE_W*r -: BYTE_W] =
            gf_mul_const(w_byte[r],               4'he) ^
            gf_mul_const(w_byte[(r + 1) % NROWS], 4'hb) ^
            gf_mul_const(w_byte[(r + 2) % NROWS], 4'hd) ^
            gf_mul_const(w_byte[(r + 3) % NROWS], 4'h9);
    end

endmodule : inv_mix_columns_seq_single_column
`default_nettype wire

// File: rtl/inv_mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module      : inv_mix_columns_seq
//  Description : Iterative InvMixColumns engine. Accepts one 128-bit state,
//                transforms one column per cycle through a single shared
//                column datapath, then holds the result for the consumer.
//                A per-transaction bypass skips the transform entirely.
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_mix_columns_seq
    import inv_mix_columns_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_bypass,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state
);

    localparam logic [COL_IDX_W-1:0] c_last_col = COL_IDX_W'(NCOLS - 1);

    fsm_t                 r_fsm;
    fsm_t                 w_fsm_next;
    logic [COL_IDX_W-1:0] r_col;
    logic [STATE_W-1:0]   r_buf;

    logic [COL_W-1:0]     w_cols [NCOLS];
    logic [COL_W-1:0]     w_cur_col;
    logic [COL_W-1:0]     w_new_col;
    logic [STATE_W-1:0]   w_buf_run;
    logic                 w_accept;
    logic                 w_out_fire;
    logic                 w_last_col;

    assign w_accept   = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_last_col = (r_col == c_last_col);

    // Split the buffer into columns, and build the write-back image in which
    // only the column under work is replaced by the datapath result.
    for (genvar g = 0; g < NCOLS; g++) begin : g_col
        localparam logic [COL_IDX_W-1:0] c_col_idx = COL_IDX_W'(g);
        assign w_cols[g] = r_buf[col_msb(g) -: COL_W];
        assign w_buf_run[col_msb(g) -: COL_W] =
            (r_col == c_col_idx) ? w_new_col : w_cols[g];
    end

    assign w_cur_col = w_cols[r_col];

    // The one shared column transform; all four columns time-share it.
    inv_mix_columns_seq_single_column u_inverse_mix_single_column (
        .current_column (w_cur_col),
        .new_column     (w_new_col)
    );

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Next-state decode: bypass jumps straight to DONE, RUN always takes
    // exactly NCOLS cycles, DONE waits for the consumer.
    always_comb begin
        w_fsm_next = r_fsm;
        unique case (r_fsm)
            IDLE: begin
                if (w_accept) begin
                    w_fsm_next = in_bypass ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last_col) begin
                    w_fsm_next = DONE;
                end
            end
            DONE: begin
                if (w_out_fire) begin
                    w_fsm_next = IDLE;
                end
            end
            default: begin
                w_fsm_next = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state alone, so no combinational
    // path exists from in_valid or out_ready.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_fsm)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign out_state = r_buf;

    // State buffer and column pointer: load on accept, one column per RUN
    // cycle; reset discards any partially mixed state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf <= '0;
            r_col <= '0;
        end else begin
            unique case (r_fsm)
                IDLE: begin
                    if (w_accept) begin
                        r_buf <= in_state;
                        r_col <= '0;
                    end
                end
                RUN: begin
                    r_buf <= w_buf_run;
                    r_col <= r_col + 1'b1;
                end
                default: begin
                    r_buf <= r_buf;
                    r_col <= r_col;
                end
            endcase
        end
    end

endmodule : inv_mix_columns_seq
`default_nettype wire
